enc_round_sequencer: RTL and testbench

Top-level scheduler for the matrix encoder.
- Runs the encoder stage blocks (column parity, rotate, permute, etc.) in fixed order for a configured number of rounds, using a start/done handshake per stage.
- All stages share one 64-line x 25-bit state memory. This block grants that memory's address and write port to the currently active stage only.
- Sits between the host start/done interface and the per-stage function blocks.

---
 rtl/enc_pkg.sv | 36 +++
 rtl/enc_round_sequencer_if.sv | 49 ++++
 rtl/enc_round_sequencer_stage_port_mux.sv | 44 ++++
 rtl/enc_round_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_enc_round_sequencer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enc_pkg
// Description : Shared definitions for the matrix-encoder round sequencer:
//               state-memory geometry, index widths, FSM state encoding and
//               a one-hot decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package enc_pkg;

  localparam int NUM_LINES   = 64;                  // state memory depth
  localparam int LINE_W      = 25;                  // state memory line width
  localparam int ADDR_W      = $clog2(NUM_LINES);   // 6-bit line address
  localparam int STAGE_IDX_W = 3;                   // width of stage_idx
  localparam int ROUND_IDX_W = 5;                   // width of round_idx
  localparam int MAX_STAGES  = 1 << STAGE_IDX_W;    // largest stage count a 3-bit index can address

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_NEXT   = 3'd3,
    ST_FINISH = 3'd4
  } seq_state_e;

  // Decode a stage index into a one-hot vector wide enough for any index;
  // callers size-cast the result down to their own stage count.
  function automatic logic [MAX_STAGES-1:0] onehot(input logic [STAGE_IDX_W-1:0] idx);
    logic [MAX_STAGES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/enc_round_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : enc_round_sequencer_if
// Description : Bundle of host handshake, per-stage handshake/memory request
//               and shared memory grant signals around the round sequencer.
//   master : the sequencer (drives busy/done/stage_start/mem_*/status)
//   slave  : the environment (host + stage blocks)
//   start/busy/done          host handshake
//   stage_start/stage_done   per-stage one-hot handshake
//   stage_addr/we/wdata      per-stage memory requests (packed by stage)
//   mem_addr/we/wdata        granted shared memory port
//   round_idx/stage_idx      progress indices
//   proto_err/timeout        sticky status flags
// Revision    : 1.0 - initial release
// ============================================================================
interface enc_round_sequencer_if
  import enc_pkg::*;
#(
  parameter int NUM_STAGES = 5
);
  logic                           start;
  logic                           busy;
  logic                           done;
  logic [NUM_STAGES-1:0]          stage_start;
  logic [NUM_STAGES-1:0]          stage_done;
  logic [NUM_STAGES*ADDR_W-1:0]   stage_addr;
  logic [NUM_STAGES-1:0]          stage_we;
  logic [NUM_STAGES*LINE_W-1:0]   stage_wdata;
  logic [ADDR_W-1:0]              mem_addr;
  logic                           mem_we;
  logic [LINE_W-1:0]              mem_wdata;
  logic [ROUND_IDX_W-1:0]         round_idx;
  logic [STAGE_IDX_W-1:0]         stage_idx;
  logic                           proto_err;
  logic                           timeout;

  modport master (
    input  start, stage_done, stage_addr, stage_we, stage_wdata,
    output busy, done, stage_start, mem_addr, mem_we, mem_wdata,
           round_idx, stage_idx, proto_err, timeout
  );

  modport slave (
    output start, stage_done, stage_addr, stage_we, stage_wdata,
    input  busy, done, stage_start, mem_addr, mem_we, mem_wdata,
           round_idx, stage_idx, proto_err, timeout
  );
endinterface
`default_nettype wire

// File: rtl/enc_round_sequencer_stage_port_mux.sv
`default_nettype none
// ============================================================================
// Module      : stage_port_mux
// Description : Combinational grant of the shared state-memory port to one
//               stage. With grant_valid low, or no stage selected, the port
//               is driven to all zeros so no stray write can occur.
//   stage_sel    in   index of the active stage
//   grant_valid  in   port may be granted this cycle
//   stage_addr   in   per-stage addresses, stage i at [i*ADDR_W +: ADDR_W]
//   stage_we     in   per-stage write enables
//   stage_wdata  in   per-stage write data, stage i at [i*LINE_W +: LINE_W]
//   mem_addr/mem_we/mem_wdata  out  granted memory port
// Revision    : 1.0 - initial release
// ============================================================================
module stage_port_mux
  import enc_pkg::*;
#(
  parameter int NUM_STAGES = 5
) (
  input  logic [STAGE_IDX_W-1:0]        stage_sel,
  input  logic                          grant_valid,
  input  logic [NUM_STAGES*ADDR_W-1:0]  stage_addr,
  input  logic [NUM_STAGES-1:0]         stage_we,
  input  logic [NUM_STAGES*LINE_W-1:0]  stage_wdata,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_we,
  output logic [LINE_W-1:0]             mem_wdata
);

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (grant_valid && (int'(stage_sel) == i)) begin
        mem_addr  = stage_addr[i*ADDR_W +: ADDR_W];
        mem_we    = stage_we[i];
        mem_wdata = stage_wdata[i*LINE_W +: LINE_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/enc_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : enc_round_sequencer
// Description : Top-level scheduler for the matrix encoder. Launches each
//               stage block in order with a one-cycle start pulse, waits for
//               its done, and repeats for NUM_ROUNDS rounds. The shared
//               state memory port is granted to the active stage only.
//   clk  in   clock, rising edge
//   rst  in   synchronous active-low reset
//   bus  master side of enc_round_sequencer_if (host handshake, stage
//        handshakes, memory grant, indices and status flags)
// Build option: define STAGE_TIMEOUT_EN to add a per-stage watchdog that
//               aborts a stuck stage after TIMEOUT_CYCLES WAIT cycles and
//               raises the sticky timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module enc_round_sequencer
  import enc_pkg::*;
#(
  parameter int NUM_STAGES     = 5,
  parameter int NUM_ROUNDS     = 24,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  enc_round_sequencer_if.master  bus
);

  seq_state_e               state_q, state_d;
  logic [STAGE_IDX_W-1:0]   stage_idx_q, stage_idx_d;
  logic [ROUND_IDX_W-1:0]   round_idx_q, round_idx_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     proto_err_q, proto_err_d;
  logic                     timeout_q, timeout_d;
  logic [NUM_STAGES-1:0]    stage_start_q, stage_start_d;

  logic [NUM_STAGES-1:0]    active_mask;
  logic                     active_done;
  logic                     wd_expired;
  logic                     grant_valid;

  assign active_mask = NUM_STAGES'(onehot(stage_idx_q));
  assign active_done = |(bus.stage_done & active_mask);
  assign grant_valid = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);

`ifdef STAGE_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

  // Counter reads 0 in the first WAIT cycle, so expiry lands on the
  // TIMEOUT_CYCLES-th WAIT cycle.
  assign wd_expired = (state_q == ST_WAIT) && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == ST_LAUNCH) begin
      wd_cnt_d = '0;
    end else if ((state_q == ST_WAIT) && !wd_expired) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    stage_idx_d = stage_idx_q;
    round_idx_d = round_idx_q;
    proto_err_d = proto_err_q;
    timeout_d   = timeout_q;

    // Any done from a stage other than the active one is a protocol error.
    // It is only flagged; sequencing carries on regardless.
    if (busy_q && |(bus.stage_done & ~active_mask)) begin
      proto_err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_LAUNCH;
          stage_idx_d = '0;
          round_idx_d = '0;
          proto_err_d = 1'b0;
          timeout_d   = 1'b0;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the expiry cycle takes precedence.
        if (active_done) begin
          state_d = ST_NEXT;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_FINISH;
        end
      end
      ST_NEXT: begin
        if (stage_idx_q == STAGE_IDX_W'(NUM_STAGES - 1)) begin
          stage_idx_d = '0;
          if (round_idx_q == ROUND_IDX_W'(NUM_ROUNDS - 1)) begin
            state_d = ST_FINISH;
          end else begin
            round_idx_d = round_idx_q + 1'b1;
            state_d     = ST_LAUNCH;
          end
        end else begin
          stage_idx_d = stage_idx_q + 1'b1;
          state_d     = ST_LAUNCH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so that, once registered,
    // they line up exactly with the state they describe.
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_FINISH);
    stage_start_d = (state_d == ST_LAUNCH) ? NUM_STAGES'(onehot(stage_idx_d)) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      stage_idx_q   <= '0;
      round_idx_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      stage_start_q <= '0;
      proto_err_q   <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_idx_q   <= stage_idx_d;
      round_idx_q   <= round_idx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      stage_start_q <= stage_start_d;
      proto_err_q   <= proto_err_d;
      timeout_q     <= timeout_d;
    end
  end

  stage_port_mux #(
    .NUM_STAGES (NUM_STAGES)
  ) u_stage_port_mux (
    .stage_sel   (stage_idx_q),
    .grant_valid (grant_valid),
    .stage_addr  (bus.stage_addr),
    .stage_we    (bus.stage_we),
    .stage_wdata (bus.stage_wdata),
    .mem_addr    (bus.mem_addr),
    .mem_we      (bus.mem_we),
    .mem_wdata   (bus.mem_wdata)
  );

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.stage_start = stage_start_q;
  assign bus.round_idx   = round_idx_q;
  assign bus.stage_idx   = stage_idx_q;
  assign bus.proto_err   = proto_err_q;
  assign bus.timeout     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_enc_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_enc_round_sequencer
// Description : Directed self-checking bench for enc_round_sequencer with
//               NUM_STAGES=5, NUM_ROUNDS=2, TIMEOUT_CYCLES=8. Each stage
//               model raises done 3 cycles after its start pulse, giving a
//               5-cycle stage period (LAUNCH, 3x WAIT, NEXT).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enc_round_sequencer;
  import enc_pkg::*;

  localparam int NS = 5;
  localparam int NR = 2;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                   start_r  = 1'b0;
  logic [NS-1:0]          resp_done = '0;
  logic [NS-1:0]          inj_done  = '0;
  logic [NS-1:0]          we_r      = '1;
  logic [NS*ADDR_W-1:0]   addr_r;
  logic [NS*LINE_W-1:0]   wdata_r;
  bit                     hang0 = 1'b0;
  int                     dly [NS] = '{default: -1};

  int total = 0;
  int bad   = 0;

  enc_round_sequencer_if #(.NUM_STAGES(NS)) bus ();

  assign bus.start       = start_r;
  assign bus.stage_done  = resp_done | inj_done;
  assign bus.stage_addr  = addr_r;
  assign bus.stage_we    = we_r;
  assign bus.stage_wdata = wdata_r;

  enc_round_sequencer #(
    .NUM_STAGES     (NS),
    .NUM_ROUNDS     (NR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Stage i requests address 10+3*i with data 0x0ABC00+i (stage 2: 16 / 0x0ABC02).
  function automatic logic [ADDR_W-1:0] st_addr(input int i);
    return ADDR_W'(10 + 3 * i);
  endfunction

  function automatic logic [LINE_W-1:0] st_data(input int i);
    return LINE_W'(32'h000A_BC00 + i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Stage models: done rises in the third cycle after the start pulse.
  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (bus.stage_start[i] && !(hang0 && i == 0)) dly[i] = 3;
      else if (dly[i] >= 0) dly[i] = dly[i] - 1;
      resp_done[i] = (dly[i] == 0);
    end
  end

  // One operation, checked cycle by cycle against the 5-cycle schedule.
  task automatic run_op(input bit foreign, input bit start_busy, input int abort_at);
    int s, p, stg, rnd;
    bit launch, granted;
    @(negedge clk);
    start_r = 1'b1;
    for (int c = 1; c <= 52; c++) begin
      @(negedge clk);
      if (c == 1) start_r = 1'b0;
      if (start_busy && c == 20) start_r = 1'b1;
      if (start_busy && c == 21) start_r = 1'b0;
      if (foreign) inj_done = (c == 8) ? 5'b10000 : 5'b00000;
      if (abort_at != 0 && c == abort_at) rst = 1'b0;
      if (abort_at != 0 && c == abort_at + 1) begin
        rst = 1'b1;
        chk($sformatf("abort_busy@%0d", c),  bus.busy, 0);
        chk($sformatf("abort_done@%0d", c),  bus.done, 0);
        chk($sformatf("abort_start@%0d", c), bus.stage_start, 0);
        chk($sformatf("abort_round@%0d", c), bus.round_idx, 0);
        chk($sformatf("abort_stage@%0d", c), bus.stage_idx, 0);
        chk($sformatf("abort_memwe@%0d", c), bus.mem_we, 0);
        for (int k = 0; k < 15; k++) begin
          @(negedge clk);
          chk($sformatf("abort_quiet@%0d", k), {bus.busy, bus.done, bus.stage_start}, 0);
        end
        return;
      end

      if (c <= 50) begin
        s = (c - 1) / 5;  p = (c - 1) % 5;
        stg = s % NS;     rnd = s / NS;
        launch  = (p == 0);
        granted = (p <= 3);
      end else begin
        stg = 0; rnd = NR - 1; launch = 1'b0; granted = 1'b0;
      end

      if (c <= 51) begin
        chk($sformatf("busy@%0d", c),  bus.busy, 1);
        chk($sformatf("done@%0d", c),  bus.done, (c == 51));
        chk($sformatf("sstart@%0d", c), bus.stage_start, launch ? (32'd1 << stg) : 0);
        chk($sformatf("stage@%0d", c), bus.stage_idx, stg);
        chk($sformatf("round@%0d", c), bus.round_idx, rnd);
        chk($sformatf("memwe@%0d", c), bus.mem_we, granted);
        chk($sformatf("memaddr@%0d", c), bus.mem_addr, granted ? st_addr(stg) : 0);
        chk($sformatf("memdata@%0d", c), bus.mem_wdata, granted ? st_data(stg) : 0);
      end else begin
        chk("busy_end", bus.busy, 0);
        chk("done_end", bus.done, 0);
        chk("sstart_end", bus.stage_start, 0);
      end
      chk($sformatf("proto@%0d", c), bus.proto_err, (foreign && c >= 9));
      chk($sformatf("tmo@%0d", c), bus.timeout, 0);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      addr_r[i*ADDR_W +: ADDR_W]  = st_addr(i);
      wdata_r[i*LINE_W +: LINE_W] = st_data(i);
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",   bus.busy, 0);
    chk("rst_done",   bus.done, 0);
    chk("rst_sstart", bus.stage_start, 0);
    chk("rst_round",  bus.round_idx, 0);
    chk("rst_stage",  bus.stage_idx, 0);
    chk("rst_memwe",  bus.mem_we, 0);
    chk("rst_maddr",  bus.mem_addr, 0);
    chk("rst_mdata",  bus.mem_wdata, 0);
    chk("rst_proto",  bus.proto_err, 0);
    chk("rst_tmo",    bus.timeout, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_op(1'b0, 1'b0, 0);    // nominal
    run_op(1'b1, 1'b1, 0);    // foreign done + start while busy
    run_op(1'b0, 1'b0, 0);    // proto_err cleared by accepted start
    run_op(1'b0, 1'b0, 42);   // reset in round 1, stage 3
    run_op(1'b0, 1'b0, 0);    // normal after abort

    // Stage 0 never completes
    hang0 = 1'b1;
    @(negedge clk);
    start_r = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) start_r = 1'b0;
`ifdef STAGE_TIMEOUT_EN
      chk($sformatf("wd_done@%0d", c), bus.done, (c == 10));
      chk($sformatf("wd_tmo@%0d", c),  bus.timeout, (c >= 10));
      chk($sformatf("wd_busy@%0d", c), bus.busy, (c <= 10));
`else
      chk($sformatf("wd_done@%0d", c), bus.done, 0);
      chk($sformatf("wd_tmo@%0d", c),  bus.timeout, 0);
      chk($sformatf("wd_busy@%0d", c), bus.busy, 1);
`endif
      chk($sformatf("wd_sstart@%0d", c), bus.stage_start, (c == 1) ? 1 : 0);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    hang0 = 1'b0;
    chk("wd_rst_busy", bus.busy, 0);
    chk("wd_rst_tmo",  bus.timeout, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
`default_nettype wire
